input_conditioner_array: RTL and testbench
==========================================

# input_conditioner_array

Multi-channel, parametrised input conditioner. Each channel synchronises an asynchronous noisy input into the `clk` domain through a configurable-depth flop chain. It then debounces the input with a per-channel counter and produces registered single-cycle rising and falling edge pulses. The block sits between board-level buttons or switches and the synchronous control logic, and replaces per-signal single-channel conditioners with one instance per input bank.

## Interface

**Parameters**

- `CHANNELS`, 4: number of independent channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flop depth, ≥2.
- `WAITTIME`, 3: debounce delay in clock cycles, ≥1.
- `COUNTER_WIDTH`, 3: debounce counter width, must satisfy 2^COUNTER_WIDTH ≥ WAITTIME.
- `INVERT_MASK`, {CHANNELS{1'b0}}: bit i=1 inverts channel i before the synchroniser, for active-low inputs.
- `RESET_VALUE`, {CHANNELS{1'b0}}: per-channel conditioned level loaded at reset.

**Ports**

- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `noisysignal` input CHANNELS: asynchronous raw inputs.
- `conditioned` output CHANNELS: debounced, synchronised level per channel, registered.
- `positiveedge` output CHANNELS: 1-cycle pulse when `conditioned[i]` goes 0→1, registered.
- `negativeedge` output CHANNELS: 1-cycle pulse when `conditioned[i]` goes 1→0, registered.
- `anyedge` output 1: OR of all `positiveedge` and `negativeedge` bits, registered, same cycle as the pulses.

## Operation

**Reset** (`rst_n`=0 at a rising edge):
- All synchroniser stages of channel i load `RESET_VALUE[i]`.
- `conditioned[i]` loads `RESET_VALUE[i]`.
- Counters load 0.
- `positiveedge`, `negativeedge` and `anyedge` load 0.
- Reset overrides all other activity.

**Per channel i, on each rising edge with `rst_n`=1:**
- Synchroniser: stage0 ← `noisysignal[i]` XOR `INVERT_MASK[i]`; stage k ← stage k-1. Let `s` be the last stage.
- Two-state debounce, per channel: STABLE (`s`==`conditioned`) and PENDING (`s`!=`conditioned`).
  - If `s`==`conditioned`: counter ← 0; `conditioned` holds.
  - Else, if counter==WAITTIME-1: `conditioned` ← `s`, counter ← 0.
  - Else: counter ← counter+1.
- Any single cycle of `s`==`conditioned` during PENDING restarts the count. Glitches shorter than WAITTIME synchronised cycles are rejected completely.
- Counter never exceeds WAITTIME-1, so no wrap-around occurs.

**Edge pulses:**
- At the same edge that updates `conditioned[i]` from 0 to 1, `positiveedge[i]` ← 1. Otherwise it ← 0.
- `negativeedge[i]` behaves the same way for a 1→0 update.
- The two pulses are never high together on one channel.
- Each pulse lasts exactly one cycle.
- Pulses coincide with the first cycle in which the new `conditioned` value is visible.

**Channel independence:**
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse.
- `anyedge` is a single 1-cycle pulse covering all channels that fire in that cycle.

## Timing

- **Latency:** input change sampled at edge k updates `conditioned` at edge k+SYNC_STAGES+WAITTIME-1. That is SYNC_STAGES+WAITTIME edges including the sampling edge. Default: 5 edges.
- **Pulse timing:** pulses and `anyedge` assert on the same edge as the `conditioned` update and deassert on the next edge.
- **Minimum accepted pulse width:** SYNC_STAGES has no effect on it. An input level must persist for WAITTIME consecutive synchronised samples to be accepted.
- **Back-to-back transitions:** supported. Minimum spacing between opposite edge pulses on one channel is WAITTIME cycles.
- **Reset mid-debounce:** pending change is discarded and no pulse is emitted. After `rst_n` rises, a differing input takes the full latency again.
- **Input at reset release:** if `noisysignal` already differs from `RESET_VALUE`, a normal debounced transition and pulse follow after full latency.

## Test plan

1. **Reset:** hold `rst_n`=0 for 3 cycles with `RESET_VALUE`=4'b0101 → `conditioned`=4'b0101 and all pulses 0, for the whole reset period and the first cycle after.
2. **Clean rise, defaults:** ch0 0→1 sampled at edge 10 → `conditioned[0]`=1 and `positiveedge[0]`=1 and `anyedge`=1 after edge 14; all three return to 0 after edge 15 except `conditioned`.
3. **Glitch rejection, WAITTIME=3:**
   - ch1 high for 2 cycles, then low → no change and no pulse.
   - ch1 high 2 cycles, low 1, high 3 → a single rise, timed from the start of the last 3-cycle run.
4. **Inversion:** `INVERT_MASK`=4'b1000, ch3 driven 1→0 → `conditioned[3]` rises with `positiveedge[3]`. `negativeedge[3]` never fires.
5. **Simultaneous channels:** ch0 rises and ch2 falls on the same edge → `positiveedge`=4'b0001 and `negativeedge`=4'b0100 in the same cycle, with a single-cycle `anyedge`.
6. **Reset mid-debounce:** ch0 change in PENDING with counter=1, `rst_n`=0 for one edge → no pulse and counter 0. Input held high afterwards → rise occurs SYNC_STAGES+WAITTIME edges after reset release.

Source files
------------

// File: rtl/input_conditioner_array_if.sv
// ---------------------------------------------------------------------------
// input_conditioner_array_if
// Bundles the per-bank signals of input_conditioner_array.
//   noisysignal  [CHANNELS] raw asynchronous inputs (driven by master)
//   conditioned  [CHANNELS] debounced, synchronised level per channel
//   positiveedge [CHANNELS] 1-cycle pulse on a 0->1 conditioned update
//   negativeedge [CHANNELS] 1-cycle pulse on a 1->0 conditioned update
//   anyedge                 OR of all edge pulses of the cycle
// master: the side that drives the raw inputs; slave: the conditioner.
// ---------------------------------------------------------------------------
interface input_conditioner_array_if #(
   parameter int unsigned CHANNELS = 4
);
   logic [CHANNELS-1:0] noisysignal;
   logic [CHANNELS-1:0] conditioned;
   logic [CHANNELS-1:0] positiveedge;
   logic [CHANNELS-1:0] negativeedge;
   logic                anyedge;

   modport master (
      output noisysignal,
      input  conditioned,
      input  positiveedge,
      input  negativeedge,
      input  anyedge
   );

   modport slave (
      input  noisysignal,
      output conditioned,
      output positiveedge,
      output negativeedge,
      output anyedge
   );
endinterface

// File: rtl/input_conditioner_array.sv
// ---------------------------------------------------------------------------
// input_conditioner_array
// Multi-channel input conditioner: each channel is optionally inverted,
// synchronised through SYNC_STAGES flops, debounced by a counter that must
// see WAITTIME consecutive differing samples, and produces registered
// single-cycle rising/falling edge pulses.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    input_conditioner_array_if.slave
//          (noisysignal in; conditioned, positiveedge, negativeedge,
//           anyedge out -- all outputs registered)
// ---------------------------------------------------------------------------
module input_conditioner_array #(
   parameter int unsigned         CHANNELS      = 4,
   parameter int unsigned         SYNC_STAGES   = 2,
   parameter int unsigned         WAITTIME      = 3,
   parameter int unsigned         COUNTER_WIDTH = 3,
   parameter logic [CHANNELS-1:0] INVERT_MASK   = '0,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
   input logic                       clk,
   input logic                       rst_n,
   input_conditioner_array_if.slave  bus
);

   localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(WAITTIME - 1);

   // STABLE: synchronised sample equals the conditioned level.
   // PENDING: they differ and the counter is qualifying the new level.
   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } deb_state_e;

   logic [CHANNELS-1:0]      sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0]      s;
   logic [CHANNELS-1:0]      cond_q, cond_d;
   logic [CHANNELS-1:0]      pos_q, pos_d;
   logic [CHANNELS-1:0]      neg_q, neg_d;
   logic                     any_q;
   logic [COUNTER_WIDTH-1:0] count_q [CHANNELS];
   logic [COUNTER_WIDTH-1:0] count_d [CHANNELS];
   deb_state_e               state   [CHANNELS];

   // Synchroniser chain, all channels in parallel. Inversion happens before
   // the first flop so active-low inputs look active-high everywhere after.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values and the chain shifts by exactly one stage per clock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
      end else begin
         sync_q[0] <= bus.noisysignal ^ INVERT_MASK;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce next-state and edge-pulse decode.
   // NOTE: every output of this block gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      cond_d = cond_q;
      pos_d  = '0;
      neg_d  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         count_d[i] = '0;
         state[i]   = (s[i] == cond_q[i]) ? STABLE : PENDING;
         unique case (state[i])
            STABLE: count_d[i] = '0;
            PENDING: begin
               if (count_q[i] == LAST_COUNT) begin
                  // Level qualified: accept it and fire the matching pulse.
                  cond_d[i] = s[i];
                  pos_d[i]  = s[i];
                  neg_d[i]  = ~s[i];
               end else begin
                  count_d[i] = count_q[i] + 1'b1;
               end
            end
            default: count_d[i] = '0;
         endcase
      end
   end

   // Conditioned level, counters and pulses share one register stage so the
   // pulses coincide with the first cycle the new level is visible.
   // NOTE: the counter array is small and feeds control decisions, so it is
   // reset like any other state rather than left to power-up values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cond_q <= RESET_VALUE;
         pos_q  <= '0;
         neg_q  <= '0;
         any_q  <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
      end else begin
         cond_q <= cond_d;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
         any_q  <= |(pos_d | neg_d);
         for (int i = 0; i < CHANNELS; i++) count_q[i] <= count_d[i];
      end
   end

   assign bus.conditioned  = cond_q;
   assign bus.positiveedge = pos_q;
   assign bus.negativeedge = neg_q;
   assign bus.anyedge      = any_q;

endmodule

// File: tb/tb_input_conditioner_array.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner_array
// Directed bench for input_conditioner_array with CHANNELS=4, SYNC_STAGES=2,
// WAITTIME=3, INVERT_MASK=4'b1000, RESET_VALUE=4'b0101. A cycle-by-cycle
// vector table covers reset, clean edges, glitch rejection, inversion and
// simultaneous channels; a hand-written sequence covers reset mid-debounce.
// Inputs are applied 1 time unit after a rising edge, outputs are sampled
// 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_input_conditioner_array;

   localparam int unsigned CH = 4;

   typedef struct {
      logic          rst_n;
      logic [CH-1:0] noisy;
      logic [CH-1:0] cond;
      logic [CH-1:0] pos;
      logic [CH-1:0] neg;
      logic          any;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   input_conditioner_array_if #(.CHANNELS(CH)) bus ();

   input_conditioner_array #(
      .CHANNELS      (CH),
      .SYNC_STAGES   (2),
      .WAITTIME      (3),
      .COUNTER_WIDTH (3),
      .INVERT_MASK   (4'b1000),
      .RESET_VALUE   (4'b0101)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Append n identical cycle records to the table.
   task automatic add(input int n, input logic r, input logic [CH-1:0] ns,
                      input logic [CH-1:0] c, input logic [CH-1:0] p,
                      input logic [CH-1:0] ng, input logic a);
      vec_t v;
      v.rst_n = r; v.noisy = ns; v.cond = c; v.pos = p; v.neg = ng; v.any = a;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [CH-1:0] c,
                                input logic [CH-1:0] p, input logic [CH-1:0] ng,
                                input logic a);
      check({tag, ".cond"}, 8'(bus.conditioned),  8'(c));
      check({tag, ".pos"},  8'(bus.positiveedge), 8'(p));
      check({tag, ".neg"},  8'(bus.negativeedge), 8'(ng));
      check({tag, ".any"},  8'(bus.anyedge),      8'(a));
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.noisysignal = 4'b1101;   // matches RESET_VALUE after ch3 inversion

      // idx 0-2: reset held; idx 3: first cycle after release
      add(3, 1'b0, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      // ch0 falls, sampled at idx 4 -> update at idx 8
      add(4, 1'b1, 4'b1100, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b1100, 4'b0100, 4'b0000, 4'b0001, 1'b1);
      add(1, 1'b1, 4'b1100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      // clean rise: ch0 sampled high at idx 10 -> update at idx 14
      add(4, 1'b1, 4'b1101, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b1101, 4'b0101, 4'b0001, 4'b0000, 1'b1);
      add(1, 1'b1, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      // ch1 glitch of 2 cycles: rejected
      add(2, 1'b1, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      add(6, 1'b1, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      // ch1 high 2, low 1, high 3+: rise timed from idx 27 -> idx 31
      add(2, 1'b1, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      add(4, 1'b1, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b1111, 4'b0111, 4'b0010, 4'b0000, 1'b1);
      add(1, 1'b1, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
      // ch3 inverted: raw 1->0 at idx 33 -> conditioned rises at idx 37
      add(4, 1'b1, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b0111, 4'b1111, 4'b1000, 4'b0000, 1'b1);
      add(1, 1'b1, 4'b0111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      // ch0 falls (setup for the simultaneous case), idx 39 -> idx 43
      add(4, 1'b1, 4'b0110, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b0110, 4'b1110, 4'b0000, 4'b0001, 1'b1);
      add(1, 1'b1, 4'b0110, 4'b1110, 4'b0000, 4'b0000, 1'b0);
      // ch0 rises and ch2 falls together, idx 45 -> idx 49
      add(4, 1'b1, 4'b0011, 4'b1110, 4'b0000, 4'b0000, 1'b0);
      add(1, 1'b1, 4'b0011, 4'b1011, 4'b0001, 4'b0100, 1'b1);
      add(2, 1'b1, 4'b0011, 4'b1011, 4'b0000, 4'b0000, 1'b0);

      foreach (vecs[i]) begin
         rst_n           = vecs[i].rst_n;
         bus.noisysignal = vecs[i].noisy;
         step();
         check_outputs($sformatf("v%0d", i), vecs[i].cond, vecs[i].pos,
                       vecs[i].neg, vecs[i].any);
      end

      // Reset mid-debounce: ch0 starts falling, counter reaches 1, then reset.
      bus.noisysignal = 4'b0010;
      step();                                             // sample edge
      check_outputs("mid.a0", 4'b1011, 4'b0000, 4'b0000, 1'b0);
      step();
      check_outputs("mid.a1", 4'b1011, 4'b0000, 4'b0000, 1'b0);
      step();                                             // first PENDING eval
      check("mid.count1", 8'(dut.count_q[0]), 8'd1);
      rst_n = 1'b0;
      step();
      check_outputs("mid.rst", 4'b0101, 4'b0000, 4'b0000, 1'b0);
      check("mid.count0", 8'(dut.count_q[0]), 8'd0);
      // After release every channel differs from RESET_VALUE (raw 0010 with
      // ch3 inverted is 1010), so all four transition after full latency.
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check_outputs($sformatf("rel.e%0d", k), 4'b0101, 4'b0000, 4'b0000, 1'b0);
      end
      step();
      check_outputs("rel.e5", 4'b1010, 4'b1010, 4'b0101, 1'b1);
      step();
      check_outputs("rel.e6", 4'b1010, 4'b0000, 4'b0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
